// File: rtl/niosii_sys_irq_ctrl_if.sv
// niosii_sys_irq_ctrl_if: Avalon-MM slave bus for the interrupt aggregator
interface niosii_sys_irq_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  modport slave (input address, chipselect, write_n, writedata, output readdata);
  modport master (output address, chipselect, write_n, writedata, input readdata);
endinterface

// File: rtl/niosii_sys_irq_ctrl.sv
// niosii_sys_irq_ctrl: level/edge interrupt aggregator with mask, vector and registered irq; NIOSII_SYS_IRQ_CTRL_SYNC_EN adds 2-flop input sync
module niosii_sys_irq_ctrl #(
  parameter int NUM_IRQ = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_IRQ-1:0]     irq_in,
  niosii_sys_irq_ctrl_if.slave   bus,
  output logic                   irq
);
  localparam logic [15:0] VALID = 16'((32'h1 << NUM_IRQ) - 1);
  logic [15:0] r_pend, r_mask, r_edge, r_s_d, r_readdata;
  logic [15:0] w_in, w_s, w_rise, w_set, w_clr, w_chg, w_next, w_active, w_vector, w_rd;
  logic [3:0]  w_idx;
  logic        w_wr;
  assign w_in = 16'(irq_in);
`ifdef NIOSII_SYS_IRQ_CTRL_SYNC_EN
  logic [15:0] r_sync1, r_sync2;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_in;
      r_sync2 <= r_sync1;
    end
  end
  assign w_s = r_sync2;
`else
  assign w_s = w_in;
`endif
  assign w_wr   = bus.chipselect && !bus.write_n;
  assign w_clr  = (w_wr && bus.address == 3'd0) ? bus.writedata : '0;
  assign w_set  = (w_wr && bus.address == 3'd5) ? bus.writedata : '0;
  assign w_chg  = (w_wr && bus.address == 3'd2) ? (bus.writedata ^ r_edge) : '0;
  assign w_rise = w_s & ~r_s_d;
  // level bits follow the input; edge bits hold until cleared, set wins over clear
  assign w_next = VALID & ~w_chg &
                  ((~r_edge & w_s) | (r_edge & ((r_pend & ~w_clr) | w_rise | w_set)));
  assign w_active = r_pend & r_mask;
  always_comb begin
    w_idx = '0;
    for (int i = 15; i >= 0; i--)
      if (w_active[i]) w_idx = 4'(i);
  end
  assign w_vector = {|w_active, 11'd0, w_idx};
  always_comb
    w_rd = bus.address == 3'd0 ? r_pend :
           bus.address == 3'd1 ? r_mask :
           bus.address == 3'd2 ? r_edge :
           bus.address == 3'd3 ? w_active :
           bus.address == 3'd4 ? w_vector : 16'h0000;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend     <= '0;
      r_mask     <= '0;
      r_edge     <= '0;
      r_s_d      <= '0;
      r_readdata <= '0;
      irq        <= 1'b0;
    end else begin
      r_pend     <= w_next;
      r_s_d      <= w_s;
      r_readdata <= w_rd;
      irq        <= |w_active;
      if (w_wr && bus.address == 3'd1) r_mask <= bus.writedata & VALID;
      if (w_wr && bus.address == 3'd2) r_edge <= bus.writedata & VALID;
    end
  end
  assign bus.readdata = r_readdata;
endmodule

// File: tb/tb_niosii_sys_irq_ctrl.sv
// tb_niosii_sys_irq_ctrl: directed self-checking bench for the interrupt aggregator
module tb_niosii_sys_irq_ctrl;
`ifdef NIOSII_SYS_IRQ_CTRL_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] irq_in = '0;
  logic       irq;
  int         n_chk = 0;
  int         n_fail = 0;
  niosii_sys_irq_ctrl_if bus ();
  niosii_sys_irq_ctrl #(.NUM_IRQ(8)) u_dut (
    .clk    (clk),
    .reset  (reset),
    .irq_in (irq_in),
    .bus    (bus),
    .irq    (irq)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = a;
    bus.writedata  = d;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask
  task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string tag);
    bus.address = a;
    tick();
    chk(tag, bus.readdata, exp);
  endtask
  initial begin
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = '0;
    bus.writedata  = '0;
    repeat (2) tick();
    reset = 1'b0;
    for (int a = 0; a < 8; a++) rd(3'(a), 16'h0000, $sformatf("reset_rd%0d", a));
    chk("reset_irq", {15'd0, irq}, 16'h0000);
    wr(3'd2, 16'h0001);
    wr(3'd1, 16'h0001);
    irq_in = 8'h01;
    tick();
    irq_in = 8'h00;
    repeat (LAT) tick();
    chk("edge_irq_early", {15'd0, irq}, 16'h0000);
    bus.address = 3'd0;
    tick();
    chk("edge_pend", bus.readdata, 16'h0001);
    chk("edge_irq", {15'd0, irq}, 16'h0001);
    wr(3'd0, 16'h0001);
    chk("w1c_irq_hold", {15'd0, irq}, 16'h0001);
    tick();
    chk("w1c_irq_clr", {15'd0, irq}, 16'h0000);
    wr(3'd1, 16'h0008);
    irq_in = 8'h08;
    tick();
    repeat (LAT) tick();
    tick();
    chk("lvl_irq", {15'd0, irq}, 16'h0001);
    wr(3'd0, 16'h0008);
    chk("lvl_w1c_irq", {15'd0, irq}, 16'h0001);
    rd(3'd0, 16'h0008, "lvl_w1c_pend");
    irq_in = 8'h00;
    repeat (LAT) tick();
    tick();
    chk("lvl_drop_irq1", {15'd0, irq}, 16'h0001);
    tick();
    chk("lvl_drop_irq2", {15'd0, irq}, 16'h0000);
    irq_in = 8'h24;
    repeat (LAT) tick();
    wr(3'd1, 16'h0024);
    rd(3'd4, 16'h8002, "vec_2");
    rd(3'd3, 16'h0024, "active");
    wr(3'd1, 16'h0020);
    rd(3'd4, 16'h8005, "vec_5");
    wr(3'd1, 16'h0000);
    rd(3'd4, 16'h0000, "vec_none");
    chk("vec_irq", {15'd0, irq}, 16'h0000);
    irq_in = 8'h00;
    repeat (LAT) tick();
    tick();
    wr(3'd2, 16'h0003);
    irq_in = 8'h02;
    wr(3'd0, 16'h0002);
    repeat (LAT) tick();
    rd(3'd0, 16'h0002, "set_wins");
    irq_in = 8'h00;
    wr(3'd0, 16'h0002);
    rd(3'd0, 16'h0000, "w1c_edge");
    wr(3'd2, 16'h0083);
    wr(3'd5, 16'h0080);
    rd(3'd0, 16'h0080, "set_bit7");
    rd(3'd5, 16'h0000, "set_reads0");
    wr(3'd5, 16'h0010);
    rd(3'd0, 16'h0080, "set_level_ign");
    wr(3'd2, 16'h0003);
    rd(3'd0, 16'h0000, "mode_chg_clr");
    rd(3'd2, 16'h0003, "edge_rd");
    rd(3'd6, 16'h0000, "addr6");
    wr(3'd1, 16'hffff);
    rd(3'd1, 16'h00ff, "mask_width");
    wr(3'd5, 16'h0001);
    tick();
    chk("pre_rst_irq", {15'd0, irq}, 16'h0001);
    reset = 1'b1;
    tick();
    chk("rst_irq", {15'd0, irq}, 16'h0000);
    reset = 1'b0;
    rd(3'd1, 16'h0000, "rst_mask");
    rd(3'd0, 16'h0000, "rst_pend");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/niosii_sys_irq_ctrl.md
# niosII_sys_irq_ctrl

Interrupt aggregator sitting directly downstream of the interval timer and the other Avalon-MM peripherals in the Nios II system. It collects up to 16 peripheral `irq` lines (timer irq on bit 0), latches them as level or rising-edge events, applies a software mask, and drives a single registered interrupt request to the CPU. It also provides a priority vector for fast dispatch. It is an Avalon-MM slave with 16-bit data and a register layout in the same style as the timer.

## Interface
Parameters:
- `NUM_IRQ`, 8: number of interrupt inputs, 1..16; register bits at or above `NUM_IRQ` read 0 and ignore writes.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous reset, active-high.
- `irq_in`  in  NUM_IRQ  peripheral interrupt lines, active-high (bit 0 = timer).
- `address`  in  3  register select.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  write strobe, active-low.
- `writedata`  in  16  write data.
- `readdata`  out  16  registered read data.
- `irq`  out  1  interrupt request to CPU, registered.

## Operation
- Register map:
  - 0 = PENDING: read; write-1-to-clear, edge sources only.
  - 1 = MASK: read/write; 1 = enabled.
  - 2 = EDGE: read/write; 1 = rising-edge capture, 0 = level.
  - 3 = ACTIVE: read-only; PENDING & MASK.
  - 4 = VECTOR: read-only.
  - 5 = SET: write-1-to-set PENDING, edge sources only; reads 0.
  - 6, 7: read 0; writes ignored.
- Write strobe: `chipselect && !write_n` at the addressed register.
- Input sample `s[i]`: `irq_in[i]`, or the synchronizer output when enabled (see Configuration). `s_d` is `s` delayed one clock.
- Level source (EDGE[i]=0):
  - PENDING[i] <= s[i] every clock.
  - W1C and SET are ignored.
- Edge source (EDGE[i]=1):
  - Set on `s[i] & ~s_d[i]` or on SET write bit.
  - Cleared on PENDING write-1.
  - Set and clear in the same clock: set wins. No event is lost.
- EDGE write: PENDING bits whose mode changes are cleared in the same clock. Those bits then resume normal behaviour from the next clock.
- VECTOR:
  - bit 15 = any ACTIVE bit set.
  - bits 3:0 = index of the lowest-numbered ACTIVE bit (lowest index = highest priority).
  - All zero when nothing is active.
- `irq` <= |(PENDING & MASK), registered.
- `readdata` <= mux(address), every clock regardless of `chipselect`.

## Timing
- Reset values: PENDING=0, MASK=0, EDGE=0, `s_d`=0, synchronizer flops=0, `readdata`=0, `irq`=0.
- Because `s_d` resets to 0, an edge source held high through reset release logs one event on the first clock after reset. This is intended.
- Latency, macro off: `irq_in` sampled high at edge k gives PENDING=1 after edge k and `irq`=1 after edge k+1.
- Latency, macro on: add 2 clocks.
- Read latency: 1 clock. `readdata` is valid the clock after `address` is presented. VECTOR and ACTIVE reflect PENDING/MASK as of that sample edge.
- Write takes effect at the edge where the strobe is sampled. Example: W1C of the only active bit at edge k gives `irq`=0 after edge k+1.
- MASK write and pending change in the same clock: `irq` uses the new values one clock later.
- Reset asserted mid-operation clears all state at that edge. `irq` is 0 from the next clock.

## Configuration
- `NIOSII_SYS_IRQ_CTRL_SYNC_EN` defined:
  - Each `irq_in` bit passes through a 2-flop synchronizer (reset 0) before `s`.
  - Input-to-PENDING latency becomes 3 clocks; input-to-`irq` becomes 4 clocks.
- Not defined:
  - `s` = `irq_in` directly (all sources are synchronous to `clk`).
  - Latencies as in Timing.
- Register map and all other behaviour are identical in both builds.

## Test plan
All scenarios run with macro undefined unless stated; `NUM_IRQ`=8.
- Reset, then read addresses 0..7: every read returns 0x0000; `irq`=0.
- EDGE=0x0001, MASK=0x0001, 1-clock pulse on `irq_in[0]` at edge k:
  - PENDING=0x0001 after edge k; `irq`=1 after edge k+1.
  - Write 0x0001 to address 0: `irq`=0 two clocks later.
- Level source 3, MASK=0x0008, `irq_in[3]` held high:
  - W1C to PENDING has no effect; `irq` stays 1.
  - Drop input: `irq`=0 two clocks later.
- `irq_in[5]` and `irq_in[2]` active, MASK=0x0024:
  - VECTOR reads 0x8002.
  - Mask bit 2 (MASK=0x0020): VECTOR reads 0x8005.
  - MASK=0: VECTOR reads 0x0000 and `irq`=0.
- Edge source 1: rising edge on `irq_in[1]` in the same clock as a W1C of bit 1. PENDING bit 1 reads 1 (set wins). SET write 0x0080 sets PENDING bit 7.
- Macro defined: pulse `irq_in[0]` at edge k with EDGE/MASK bit 0 set. PENDING=1 after edge k+2; `irq`=1 after edge k+3.
